// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store; data has priority, but fetch is forced after STARVE_LIMIT data grants.
// Latency: a request sampled at edge E gets its ready pulse in cycle E+LATENCY; one access per LATENCY+1 cycles.
// Backpressure: a requester holds req and fields until granted; no grant is made while an access is in progress.
module mem_port_arbiter #(
  parameter int LATENCY      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_ctrl,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic        mem_usignext,
  output logic [1:0]  mem_width,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_INIT     = CW'(LATENCY - 1);
  localparam logic [SW-1:0] STARVE_MAX   = SW'(STARVE_LIMIT);
  localparam logic          SINGLE_CYCLE = (LATENCY == 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [SW-1:0] starve_q, starve_d;
  logic          owner_data_q;
  logic          store_q;
  logic [31:0]   mem_addr_q, mem_wdata_q;
  logic [1:0]    mem_width_q;
  logic          mem_usx_q, mem_we_q;
  logic [31:0]   if_rdata_q, d_rdata_q;
  logic          if_ready_q, d_ready_q, busy_q;

  logic          can_grant, fetch_forced, grant_data, grant_fetch;

  // Grant decision for the coming edge and the next value of the starvation counter.
  always_comb begin
    can_grant    = (state_q != S_ACCESS);
    fetch_forced = if_req && (starve_q == STARVE_MAX);
    grant_data   = can_grant && d_req && !fetch_forced;
    grant_fetch  = can_grant && if_req && !grant_data;
    starve_d     = starve_q;
    if (grant_fetch) begin
      starve_d = '0;
    end else if (grant_data && if_req && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Port sequencer: grant in IDLE/RESP, hold the port for LATENCY cycles, then deliver one ready pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      starve_q     <= '0;
      owner_data_q <= 1'b0;
      store_q      <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_width_q  <= 2'b10;
      mem_usx_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_ready_q   <= 1'b0;
      d_ready_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      starve_q   <= starve_d;
      case (state_q)
        S_ACCESS: begin
          if (cnt_q == '0) begin
            // Final access cycle: the memory output belongs to the current owner.
            if (owner_data_q) begin
              d_rdata_q <= mem_rdata;
              d_ready_q <= 1'b1;
            end else begin
              if_rdata_q <= mem_rdata;
              if_ready_q <= 1'b1;
            end
            mem_we_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= S_RESP;
          end else begin
            cnt_q    <= cnt_q - CW'(1);
            // The write strobe only covers the last held cycle, so a store writes once.
            mem_we_q <= store_q && (cnt_q == CW'(1));
          end
        end
        default: begin
          if (grant_data) begin
            owner_data_q <= 1'b1;
            store_q      <= d_we;
            mem_addr_q   <= d_addr;
            mem_wdata_q  <= d_wdata;
            mem_usx_q    <= d_ctrl[2];
            mem_width_q  <= d_ctrl[1:0];
            mem_we_q     <= d_we && SINGLE_CYCLE;
            cnt_q        <= CNT_INIT;
            busy_q       <= 1'b1;
            state_q      <= S_ACCESS;
          end else if (grant_fetch) begin
            // Fetch always reads a full word; the write data register is left as is.
            owner_data_q <= 1'b0;
            store_q      <= 1'b0;
            mem_addr_q   <= if_addr;
            mem_usx_q    <= 1'b0;
            mem_width_q  <= 2'b10;
            mem_we_q     <= 1'b0;
            cnt_q        <= CNT_INIT;
            busy_q       <= 1'b1;
            state_q      <= S_ACCESS;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign if_rdata     = if_rdata_q;
  assign if_ready     = if_ready_q;
  assign d_rdata      = d_rdata_q;
  assign d_ready      = d_ready_q;
  assign mem_addr     = mem_addr_q;
  assign mem_we       = mem_we_q;
  assign mem_usignext = mem_usx_q;
  assign mem_width    = mem_width_q;
  assign mem_wdata    = mem_wdata_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (LATENCY=2/STARVE_LIMIT=4 and LATENCY=1/STARVE_LIMIT=1).
// Each instance drives its own byte memory; a transaction-level model predicts every output each cycle.
// Random requesters with a scripted prefix, plus an asynchronous reset in the middle of a store.
module tb_mem_port_arbiter;

  localparam int NU = 2;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
  } dreq_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req [NU];
  logic [31:0] if_addr [NU];
  logic [31:0] if_rdata [NU];
  logic        if_ready [NU];
  logic        d_req [NU];
  logic        d_we [NU];
  logic [31:0] d_addr [NU];
  logic [31:0] d_wdata [NU];
  logic [2:0]  d_ctrl [NU];
  logic [31:0] d_rdata [NU];
  logic        d_ready [NU];
  logic [31:0] mem_addr [NU];
  logic        mem_we [NU];
  logic        mem_usignext [NU];
  logic [1:0]  mem_width [NU];
  logic [31:0] mem_wdata [NU];
  logic [31:0] mem_rdata [NU];
  logic        busy [NU];

  always #5 clk = ~clk;

  mem_port_arbiter #(.LATENCY(2), .STARVE_LIMIT(4)) u_dut0 (
    .clk(clk), .reset(rst_n),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rdata(if_rdata[0]), .if_ready(if_ready[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]), .d_ctrl(d_ctrl[0]),
    .d_rdata(d_rdata[0]), .d_ready(d_ready[0]),
    .mem_addr(mem_addr[0]), .mem_we(mem_we[0]), .mem_usignext(mem_usignext[0]),
    .mem_width(mem_width[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  mem_port_arbiter #(.LATENCY(1), .STARVE_LIMIT(1)) u_dut1 (
    .clk(clk), .reset(rst_n),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rdata(if_rdata[1]), .if_ready(if_ready[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]), .d_ctrl(d_ctrl[1]),
    .d_rdata(d_rdata[1]), .d_ready(d_ready[1]),
    .mem_addr(mem_addr[1]), .mem_we(mem_we[1]), .mem_usignext(mem_usignext[1]),
    .mem_width(mem_width[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  // Memories: tbm is driven by the DUT port, rmem is the reference image updated by the model.
  logic [7:0]  tbm  [NU][1024];
  logic [7:0]  rmem [NU][1024];

  // Model state per instance.
  int          cyc;
  int          rc [NU];
  bit          own_d [NU];
  bit          m_we [NU];
  logic [31:0] m_addr [NU];
  logic [31:0] m_wdata [NU];
  logic [1:0]  m_w [NU];
  logic        m_u [NU];
  int          stv [NU];
  logic [31:0] e_ird [NU];
  logic [31:0] e_drd [NU];
  bit          gr_f [NU];
  bit          gr_d [NU];

  // Pending memory write seen on the port in the previous cycle.
  bit          p_we [NU];
  logic [31:0] p_addr [NU];
  logic [1:0]  p_w [NU];
  logic [31:0] p_data [NU];

  logic [31:0] fq [NU][$];
  dreq_t       dq [NU][$];

  int n_checks = 0;
  int n_errors = 0;

  function automatic int lat_of(input int u);
    return (u == 0) ? 2 : 1;
  endfunction

  function automatic int lim_of(input int u);
    return (u == 0) ? 4 : 1;
  endfunction

  function automatic logic [31:0] fmt_rd(input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2, input logic [7:0] b3,
                                         input logic [1:0] w, input logic usx);
    logic [15:0] h;
    h = {b1, b0};
    case (w)
      2'b00:   fmt_rd = usx ? {24'h0, b0} : {{24{b0[7]}}, b0};
      2'b01:   fmt_rd = usx ? {16'h0, h} : {{16{h[15]}}, h};
      default: fmt_rd = {b3, b2, b1, b0};
    endcase
  endfunction

  // Combinational memory read from the port address.
  always_comb begin
    for (int u = 0; u < NU; u++) begin
      mem_rdata[u] = fmt_rd(tbm[u][mem_addr[u][9:0]], tbm[u][mem_addr[u][9:0] + 10'd1],
                            tbm[u][mem_addr[u][9:0] + 10'd2], tbm[u][mem_addr[u][9:0] + 10'd3],
                            mem_width[u], mem_usignext[u]);
    end
  end

  function automatic logic [31:0] ref_rd(input int u, input logic [31:0] addr,
                                         input logic [1:0] w, input logic usx);
    logic [9:0] a;
    a = addr[9:0];
    return fmt_rd(rmem[u][a], rmem[u][a + 10'd1], rmem[u][a + 10'd2], rmem[u][a + 10'd3], w, usx);
  endfunction

  task automatic put_bytes(input bit to_ref, input int u, input logic [31:0] addr,
                           input logic [1:0] w, input logic [31:0] data);
    logic [9:0] a;
    int n;
    a = addr[9:0];
    n = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    for (int k = 0; k < n; k++) begin
      if (to_ref) rmem[u][a + 10'(k)] = data[8*k +: 8];
      else        tbm[u][a + 10'(k)]  = data[8*k +: 8];
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < NU; u++) begin
      rc[u] = -100; own_d[u] = 1'b0; m_we[u] = 1'b0;
      m_addr[u] = '0; m_wdata[u] = '0; m_w[u] = 2'b10; m_u[u] = 1'b0;
      stv[u] = 0; e_ird[u] = '0; e_drd[u] = '0;
      gr_f[u] = 1'b0; gr_d[u] = 1'b0; p_we[u] = 1'b0;
    end
  endtask

  // Transaction view of one clock edge: finish an access whose time is up, or hand out the free port.
  task automatic model_edge();
    for (int u = 0; u < NU; u++) begin
      gr_f[u] = 1'b0;
      gr_d[u] = 1'b0;
      if (cyc == rc[u]) begin
        if (own_d[u]) begin
          e_drd[u] = ref_rd(u, m_addr[u], m_w[u], m_u[u]);
          if (m_we[u]) put_bytes(1'b1, u, m_addr[u], m_w[u], m_wdata[u]);
        end else begin
          e_ird[u] = ref_rd(u, m_addr[u], 2'b10, 1'b0);
        end
      end else if (cyc - 1 >= rc[u]) begin
        if (d_req[u] && !(if_req[u] && stv[u] == lim_of(u))) begin
          gr_d[u] = 1'b1;
          if (if_req[u]) stv[u] = (stv[u] < lim_of(u)) ? stv[u] + 1 : lim_of(u);
          own_d[u] = 1'b1; m_we[u] = d_we[u]; m_addr[u] = d_addr[u]; m_wdata[u] = d_wdata[u];
          m_w[u] = d_ctrl[u][1:0]; m_u[u] = d_ctrl[u][2];
          rc[u] = cyc + lat_of(u);
        end else if (if_req[u]) begin
          gr_f[u] = 1'b1;
          stv[u] = 0;
          own_d[u] = 1'b0; m_we[u] = 1'b0; m_addr[u] = if_addr[u]; m_w[u] = 2'b10; m_u[u] = 1'b0;
          rc[u] = cyc + lat_of(u);
        end
      end
    end
  endtask

  task automatic check_cycle(input int u);
    check_val($sformatf("u%0d busy", u), 32'(busy[u]), 32'(cyc < rc[u]));
    check_val($sformatf("u%0d if_ready", u), 32'(if_ready[u]), 32'(cyc == rc[u] && !own_d[u]));
    check_val($sformatf("u%0d d_ready", u), 32'(d_ready[u]), 32'(cyc == rc[u] && own_d[u]));
    check_val($sformatf("u%0d mem_we", u), 32'(mem_we[u]), 32'(own_d[u] && m_we[u] && cyc == rc[u] - 1));
    check_val($sformatf("u%0d mem_addr", u), mem_addr[u], m_addr[u]);
    check_val($sformatf("u%0d mem_width", u), 32'(mem_width[u]), 32'(m_w[u]));
    check_val($sformatf("u%0d mem_usignext", u), 32'(mem_usignext[u]), 32'(m_u[u]));
    check_val($sformatf("u%0d mem_wdata", u), mem_wdata[u], m_wdata[u]);
    check_val($sformatf("u%0d if_rdata", u), if_rdata[u], e_ird[u]);
    check_val($sformatf("u%0d d_rdata", u), d_rdata[u], e_drd[u]);
  endtask

  task automatic chk_reset(input string ph);
    for (int u = 0; u < NU; u++) begin
      check_val($sformatf("%s u%0d busy", ph, u), 32'(busy[u]), 32'd0);
      check_val($sformatf("%s u%0d if_ready", ph, u), 32'(if_ready[u]), 32'd0);
      check_val($sformatf("%s u%0d d_ready", ph, u), 32'(d_ready[u]), 32'd0);
      check_val($sformatf("%s u%0d mem_we", ph, u), 32'(mem_we[u]), 32'd0);
      check_val($sformatf("%s u%0d mem_usignext", ph, u), 32'(mem_usignext[u]), 32'd0);
      check_val($sformatf("%s u%0d mem_width", ph, u), 32'(mem_width[u]), 32'd2);
      check_val($sformatf("%s u%0d mem_addr", ph, u), mem_addr[u], 32'd0);
      check_val($sformatf("%s u%0d mem_wdata", ph, u), mem_wdata[u], 32'd0);
      check_val($sformatf("%s u%0d if_rdata", ph, u), if_rdata[u], 32'd0);
      check_val($sformatf("%s u%0d d_rdata", ph, u), d_rdata[u], 32'd0);
    end
  endtask

  // Requesters: drop req and scramble fields once granted; raise a new request with probability p percent.
  task automatic drive_next(input int p);
    logic [31:0] a;
    logic [1:0]  w;
    dreq_t       r;
    for (int u = 0; u < NU; u++) begin
      p_we[u] = mem_we[u]; p_addr[u] = mem_addr[u]; p_w[u] = mem_width[u]; p_data[u] = mem_wdata[u];
      if (gr_f[u]) begin
        if_req[u] = 1'b0;
        if_addr[u] = $urandom;
      end else if (!if_req[u] && $urandom_range(99) < p) begin
        if_req[u] = 1'b1;
        if (fq[u].size() > 0) begin
          if_addr[u] = fq[u].pop_front();
        end else begin
          a = $urandom;
          a[1:0] = 2'b00;
          if_addr[u] = a;
        end
      end
      if (gr_d[u]) begin
        d_req[u] = 1'b0;
        d_addr[u] = $urandom; d_wdata[u] = $urandom;
        d_we[u] = 1'($urandom_range(1)); d_ctrl[u] = 3'($urandom_range(7));
      end else if (!d_req[u] && $urandom_range(99) < p) begin
        if (dq[u].size() > 0) begin
          r = dq[u].pop_front();
        end else begin
          w = 2'($urandom_range(2));
          a = $urandom;
          a[9:6] = 4'h0;
          if (w == 2'b01) a[0] = 1'b0;
          if (w == 2'b10) a[1:0] = 2'b00;
          r.we = 1'($urandom_range(1)); r.addr = a; r.wdata = $urandom;
          r.ctrl = {1'($urandom_range(1)), w};
        end
        d_req[u] = 1'b1; d_we[u] = r.we; d_addr[u] = r.addr; d_wdata[u] = r.wdata; d_ctrl[u] = r.ctrl;
      end
    end
  endtask

  task automatic step(input int p);
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    for (int u = 0; u < NU; u++) begin
      if (p_we[u]) put_bytes(1'b0, u, p_addr[u], p_w[u], p_data[u]);
    end
    for (int u = 0; u < NU; u++) check_cycle(u);
    drive_next(p);
  endtask

  initial begin
    logic [7:0] b;
    dreq_t      r;
    cyc = 0;
    for (int u = 0; u < NU; u++) begin
      if_req[u] = 1'b0; if_addr[u] = '0; d_req[u] = 1'b0; d_we[u] = 1'b0;
      d_addr[u] = '0; d_wdata[u] = '0; d_ctrl[u] = '0;
      for (int i = 0; i < 1024; i++) begin
        b = 8'($urandom);
        tbm[u][i] = b;
        rmem[u][i] = b;
      end
    end
    // Instruction word 0x00500093 at 0x100, and byte 0xA5 at 0x2003 for the single-cycle instance.
    put_bytes(1'b0, 0, 32'h100, 2'b10, 32'h0050_0093);
    put_bytes(1'b1, 0, 32'h100, 2'b10, 32'h0050_0093);
    put_bytes(1'b0, 1, 32'h2003, 2'b00, 32'h0000_00A5);
    put_bytes(1'b1, 1, 32'h2003, 2'b00, 32'h0000_00A5);
    fq[0].push_back(32'h100);
    r.we = 1'b1; r.addr = 32'h2000; r.wdata = 32'hDEAD_BEEF; r.ctrl = 3'b010;
    dq[0].push_back(r);
    r.we = 1'b0; r.wdata = 32'h0;
    dq[0].push_back(r);
    r.addr = 32'h2003; r.ctrl = 3'b100;
    dq[1].push_back(r);
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk_reset("por");
    rst_n = 1'b1;

    repeat (60) step(100);
    repeat (600) step(40);
    repeat (12) step(0);

    // Store on the LATENCY=2 instance, then reset during its first access cycle.
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h2000; d_wdata[0] = 32'h1234_5678; d_ctrl[0] = 3'b010;
    step(0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("rst0");
    @(posedge clk);
    #1;
    chk_reset("rst1");
    for (int i = 0; i < 4; i++) check_val($sformatf("rst mem byte %0d", i), 32'(tbm[0][i]), 32'(rmem[0][i]));
    for (int u = 0; u < NU; u++) begin
      if_req[u] = 1'b0;
      d_req[u] = 1'b0;
    end
    model_reset();
    rst_n = 1'b1;

    repeat (200) step(50);
    repeat (12) step(0);

    for (int u = 0; u < NU; u++) begin
      for (int i = 0; i < 1024; i++) begin
        check_val($sformatf("mem u%0d[%0d]", u, i), 32'(tbm[u][i]), 32'(rmem[u][i]));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences a single shared memory port between the rv32 core's instruction-fetch requester and its load/store requester, so one `memory` instance can serve as a unified instruction/data store. Each access is held on the port for `LATENCY` cycles, and the result comes back through a one-cycle ready pulse. Data accesses have priority, but a starvation counter bounds how long fetch can be locked out. The block sits between `rv32` and a single `memory`, replacing the separate imem/dmem pair.

## Interface
- `LATENCY`, 2, cycles each access is held on the memory port; must be ≥1
- `STARVE_LIMIT`, 4, consecutive data grants allowed while `if_req` is pending before fetch is forced; must be ≥1
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset)
- `if_req`  in  1  fetch request
- `if_addr`  in  32  fetch address
- `if_rdata`  out  32  fetched word; registered
- `if_ready`  out  1  one-cycle pulse: `if_rdata` is valid
- `d_req`  in  1  data request
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  32  data address
- `d_wdata`  in  32  store data
- `d_ctrl`  in  3  [2] = usignext, [1:0] = width (memory encoding)
- `d_rdata`  out  32  load result; registered
- `d_ready`  out  1  one-cycle pulse: access complete and `d_rdata` valid (loads)
- `mem_addr`  out  32  memory address
- `mem_we`  out  1  memory write enable
- `mem_usignext`  out  1  memory unsigned-extend control
- `mem_width`  out  2  memory width control
- `mem_wdata`  out  32  memory write data
- `mem_rdata`  in  32  memory read data; combinational from `mem_addr`
- `busy`  out  1  high while the FSM is in ACCESS

## Operation
- **States:**
  - IDLE: no access in progress.
  - ACCESS: port owned and held; down-counter `cnt` active.
  - RESP: result delivered.
- **Grant:** evaluated at the edge when the FSM is in IDLE or RESP.
  - Only `d_req` set → grant data.
  - Only `if_req` set → grant fetch.
  - Both set → grant data, unless `starve == STARVE_LIMIT`; then grant fetch.
  - On grant: latch owner and request fields into port registers, set `cnt = LATENCY-1`, go to ACCESS.
  - No request → IDLE.
- **Fetch access:** drives `mem_width = 2'b10`, `mem_usignext = 0`, `mem_we = 0`, `mem_wdata` unchanged.
- **Data access:** drives the latched `d_ctrl` fields and `d_wdata`.
- **ACCESS:** `cnt` decrements each edge. When `cnt == 0` at an edge:
  - capture `mem_rdata` into the owner's rdata register;
  - go to RESP.
- **RESP:** owner's ready is 1 for exactly this cycle. The non-owner's ready stays 0.
- **`mem_we`:** 1 only in the final ACCESS cycle (`cnt == 0`) of a data store. This gives exactly one write per store and keeps `mem_we` low in all other states.
- **Starvation counter `starve`:**
  - increments on each data grant made while `if_req` is high, saturating at `STARVE_LIMIT`;
  - clears to 0 on any fetch grant;
  - holds otherwise.
- **Requester rules:**
  - Request fields must stay stable from the cycle `req` is raised until the edge that grants it. After the grant, changes to the fields are ignored.
  - `req` high during its own ready cycle is a new request (back-to-back); a requester deasserts `req` in that cycle to avoid it.
- **Port registers after an access:** hold their last values through IDLE/RESP; only `mem_we` returns to 0.
- **Reset values:**
  - `if_ready = d_ready = busy = mem_we = mem_usignext = 0`
  - `if_rdata = d_rdata = mem_addr = mem_wdata = 0`
  - `mem_width = 2'b10`
  - state IDLE, `cnt = 0`, `starve = 0`

## Timing
- Request sampled at edge E → ACCESS during cycles E..E+LATENCY-1 → ready high in cycle E+LATENCY.
- Request-to-ready latency: `LATENCY` edges. Throughput: one access per `LATENCY+1` cycles with back-to-back requests.
- `LATENCY = 1`: a single ACCESS cycle, and `mem_we` is high in it for stores.
- Reset asserted mid-ACCESS:
  - all outputs go to reset values immediately, asynchronously;
  - the access is abandoned and no ready is issued;
  - a store whose final cycle has not been reached is never written.
- After reset deasserts, the first grant can occur at the next edge.

## Test plan
1. **Fetch, LATENCY=2.** `if_req=1`, `if_addr=0x100`, memory word 0x00500093 → `mem_addr=0x100` for 2 cycles, `mem_we=0`; `if_ready` pulses once with `if_rdata=0x00500093`.
2. **Store then load, same address.** Store: `d_we=1`, `d_addr=0x2000`, `d_wdata=0xDEADBEEF`, `d_ctrl=3'b010` → `mem_we` high for exactly 1 cycle, then `d_ready`. Load with `d_we=0` → `d_rdata=0xDEADBEEF`.
3. **Simultaneous requests, STARVE_LIMIT=4.** `if_req` and `d_req` both held high → grant order D, D, D, D, F, D…; `starve` returns to 0 after the fetch grant.
4. **Back-to-back fetch.** `if_req` held high → `if_ready` every 3rd cycle at LATENCY=2; `busy` low only in the RESP cycles.
5. **Reset mid-store.** Store granted; reset=0 in the first ACCESS cycle → `mem_we` never asserted, memory unchanged, `d_ready=0`, all outputs at reset values.
6. **LATENCY=1 byte load.** `d_ctrl=3'b100`, `d_addr=0x2003` → `mem_usignext=1`, `mem_width=2'b00` for 1 cycle; `d_ready` on the next cycle with the zero-extended byte.
